// File: rtl/sub_seq_128bit.sv
// sub_seq_128bit: multi-cycle unsigned subtractor, diff = a - b mod 2^WIDTH.
// One SLICE-wide chunk is processed per clock, LSB slice first, with the
// borrow between slices held in a flop.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The source holds in_valid/a/b stable until it sees in_ready; the
// result (diff, borrow_out) is stable while out_valid=1 until out_ready is
// seen. in_ready and out_valid are decoded from the state register only.
module sub_seq_128bit #(
  parameter int WIDTH = 128,
  parameter int SLICE = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  // Slice datapath signals.
  logic [31:0]      shamt;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sub;
  logic [WIDTH-1:0] slice_mask;
  logic [WIDTH-1:0] d_w;
  logic             last;

  // Current slice subtract. The right shift zero-fills, so the narrower last
  // slice needs no mask: a negative result still sets bit SLICE as the borrow.
  always_comb begin
    shamt      = 32'(idx_q) * 32'(SLICE);
    a_sl       = SLICE'(a_q >> shamt);
    b_sl       = SLICE'(b_q >> shamt);
    sub        = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, borrow_q};
    slice_mask = '0;
    slice_mask[SLICE-1:0] = '1;
    slice_mask = slice_mask << shamt;
    d_w        = '0;
    d_w[SLICE-1:0] = sub[SLICE-1:0];
    d_w        = d_w << shamt;
    last       = (idx_q == IDX_W'(NSLICE - 1));
  end

  // Next-state and register updates for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d   = (diff_q & ~slice_mask) | d_w;
        borrow_d = sub[SLICE];
        idx_d    = idx_q + 1'b1;
        if (last) begin
          borrow_out_d = sub[SLICE];
          idx_d        = '0;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule
